// File: rtl/vram_pkg.sv
// Shared definitions for the video RAM arbitration path: grant encoding,
// default bus widths and the fetch latency the VGA fetch logic is built around.
package vram_pkg;

  // Port owner for one RAM cycle. Ownership is re-decided every cycle.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_CPU  = 2'd2
  } grant_t;

  localparam int VRAM_ADDR_W     = 15;
  localparam int VRAM_DATA_W     = 3;
  localparam int VRAM_FIFO_DEPTH = 4;

  // Cycles from iVgaReq being sampled to oVgaValid; the VGA block schedules
  // its pixel pipeline against this number.
  localparam int VRAM_FETCH_LAT  = 3;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the arbiter, the VGA fetch logic, MiniAlu stores and
// the video RAM macro.
//
// Handshake semantics:
//   - VGA fetch: iVgaReq is a one-cycle request with iVgaAddr; it is never
//     back-pressured. oVgaValid pulses exactly once per request, a fixed
//     VRAM_FETCH_LAT cycles later, with oVgaData.
//   - CPU store: a store transfers on a clock edge where iCpuWrEn && oCpuReady.
//     oCpuReady depends only on registered state, never on iCpuWrEn.
//     iCpuWrEn while oCpuReady is low is a lost store and sets oCpuOverflow.
//   - RAM: oRamAddr/oRamData/oRamWe are registered; iRamData returns the word
//     at the address presented one cycle earlier.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = VRAM_FIFO_DEPTH
);
  localparam int CNT_W = cntWidth(FIFO_DEPTH);

  logic              iVgaReq;
  logic [ADDR_W-1:0] iVgaAddr;
  logic              oVgaValid;
  logic [DATA_W-1:0] oVgaData;

  logic              iCpuWrEn;
  logic [ADDR_W-1:0] iCpuAddr;
  logic [DATA_W-1:0] iCpuData;
  logic              oCpuReady;
  logic              oCpuOverflow;

  logic [ADDR_W-1:0] oRamAddr;
  logic [DATA_W-1:0] oRamData;
  logic              oRamWe;
  logic [DATA_W-1:0] iRamData;

  // Observation points: current grant and write-buffer occupancy.
  grant_t            dbgGntState;
  logic [CNT_W-1:0]  dbgFifoCount;

  // Arbiter side.
  modport slave (
    input  iVgaReq, iVgaAddr, iCpuWrEn, iCpuAddr, iCpuData, iRamData,
    output oVgaValid, oVgaData, oCpuReady, oCpuOverflow,
    output oRamAddr, oRamData, oRamWe, dbgGntState, dbgFifoCount
  );

  // Client / RAM side.
  modport master (
    output iVgaReq, iVgaAddr, iCpuWrEn, iCpuAddr, iCpuData, iRamData,
    input  oVgaValid, oVgaData, oCpuReady, oCpuOverflow,
    input  oRamAddr, oRamData, oRamWe, dbgGntState, dbgFifoCount
  );

endinterface

// File: rtl/vram_write_fifo.sv
// Small synchronous FIFO buffering {addr,data} pixel stores until the RAM
// port is free. No bypass: an entry is visible at the head only from the
// cycle after it was pushed.
module vram_write_fifo
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W,
  parameter int DEPTH  = VRAM_FIFO_DEPTH
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iPush,
  input  logic [ADDR_W-1:0]        iPushAddr,
  input  logic [DATA_W-1:0]        iPushData,
  input  logic                     iPop,
  output logic [ADDR_W-1:0]        oHeadAddr,
  output logic [DATA_W-1:0]        oHeadData,
  output logic                     oFull,
  output logic                     oEmpty,
  output logic [cntWidth(DEPTH)-1:0] oCount
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cntWidth(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  // Guard against caller misuse so the pointers can never desynchronise.
  assign doPush = iPush && !oFull;
  assign doPop  = iPop  && !oEmpty;

  assign oFull  = (count == CNT_W'(DEPTH));
  assign oEmpty = (count == '0);
  assign oCount = count;
  assign {oHeadAddr, oHeadData} = mem[rdPtr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until counted as valid.
  always_ff @(posedge Clock) begin
    if (doPush) mem[wrPtr] <= {iPushAddr, iPushData};
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter. VGA scanout reads always win the port;
// MiniAlu stores are buffered and drained in any cycle VGA leaves free.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = VRAM_FIFO_DEPTH
) (
  input logic           Clock,
  input logic           Reset,
  vram_arbiter_if.slave bus
);
  localparam int CNT_W = cntWidth(FIFO_DEPTH);

  grant_t            gntState;
  grant_t            gntNext;

  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;
  logic              cpuReady;
  logic              cpuPush;
  logic              fifoPop;

  logic [ADDR_W-1:0] ramAddrQ;
  logic [DATA_W-1:0] ramDataQ;
  logic              ramWeQ;
  logic [ADDR_W-1:0] ramAddrNext;
  logic [DATA_W-1:0] ramDataNext;
  logic              ramWeNext;

  logic              fetchVld2;
  logic              vgaValidQ;
  logic [DATA_W-1:0] vgaDataQ;
  logic              overflowQ;

  // Ready comes from the registered count only, so it never depends on iCpuWrEn.
  assign cpuReady = !fifoFull;
  assign cpuPush  = bus.iCpuWrEn && cpuReady;

  vram_write_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) uWriteFifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .iPush     (cpuPush),
    .iPushAddr (bus.iCpuAddr),
    .iPushData (bus.iCpuData),
    .iPop      (fifoPop),
    .oHeadAddr (headAddr),
    .oHeadData (headData),
    .oFull     (fifoFull),
    .oEmpty    (fifoEmpty),
    .oCount    (fifoCount)
  );

  // Grant state register: one owner per RAM cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) gntState <= GNT_IDLE;
    else       gntState <= gntNext;
  end

  // Next owner: VGA is hard real-time, CPU only drains buffered stores, so an
  // entry pushed this cycle cannot be granted until the next one.
  always_comb begin
    gntNext = GNT_IDLE;
    if (bus.iVgaReq)     gntNext = GNT_VGA;
    else if (!fifoEmpty) gntNext = GNT_CPU;
  end

  // RAM port values for the upcoming cycle; idle holds address/data to avoid
  // needless toggling on the RAM pins.
  always_comb begin
    ramAddrNext = ramAddrQ;
    ramDataNext = ramDataQ;
    ramWeNext   = 1'b0;
    fifoPop     = 1'b0;
    case (gntNext)
      GNT_VGA: begin
        ramAddrNext = bus.iVgaAddr;
      end
      GNT_CPU: begin
        ramAddrNext = headAddr;
        ramDataNext = headData;
        ramWeNext   = 1'b1;
        fifoPop     = 1'b1;
      end
      default: begin
        ramWeNext   = 1'b0;
      end
    endcase
  end

  // Registered RAM drive, captured together with the grant.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ramAddrQ <= '0;
      ramDataQ <= '0;
      ramWeQ   <= 1'b0;
    end else begin
      ramAddrQ <= ramAddrNext;
      ramDataQ <= ramDataNext;
      ramWeQ   <= ramWeNext;
    end
  end

  // Fetch return pipeline: VGA grant -> RAM data valid -> registered pixel.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      fetchVld2 <= 1'b0;
      vgaValidQ <= 1'b0;
      vgaDataQ  <= '0;
    end else begin
      fetchVld2 <= (gntState == GNT_VGA);
      vgaValidQ <= fetchVld2;
      if (fetchVld2) vgaDataQ <= bus.iRamData;
    end
  end

  // Sticky record of any store lost to a full buffer.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                            overflowQ <= 1'b0;
    else if (bus.iCpuWrEn && !cpuReady)   overflowQ <= 1'b1;
  end

  assign bus.oRamAddr     = ramAddrQ;
  assign bus.oRamData     = ramDataQ;
  assign bus.oRamWe       = ramWeQ;
  assign bus.oVgaValid    = vgaValidQ;
  assign bus.oVgaData     = vgaDataQ;
  assign bus.oCpuReady    = cpuReady;
  assign bus.oCpuOverflow = overflowQ;
  assign bus.dbgGntState  = gntState;
  assign bus.dbgFifoCount = fifoCount;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected fetch results
// and RAM writes (with the cycle they must appear in); a negedge monitor
// pops and compares whenever the DUT presents a fetch or a write.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int CYC_W      = 16;
  localparam int VW         = CYC_W + DATA_W;
  localparam int WW         = CYC_W + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic Clock;
  logic Reset;
  int   cyc = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Synchronous read-first RAM model, one cycle read latency.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge Clock) begin
    bus.iRamData <= ram[bus.oRamAddr];
    if (bus.oRamWe) ram[bus.oRamAddr] <= bus.oRamData;
  end

  // ---------------- scoreboard ----------------
  logic [VW-1:0] vga_exp_q[$];
  logic [WW-1:0] wr_exp_q[$];
  int checks   = 0;
  int failures = 0;

  logic [VW-1:0] vga_got, vga_exp;
  logic [WW-1:0] wr_got, wr_exp;

  always @(negedge Clock) begin
    if (!Reset) begin
      if (bus.oVgaValid) begin
        vga_got = {CYC_W'(cyc), bus.oVgaData};
        checks++;
        if (vga_exp_q.size() == 0) begin
          failures++;
          $display("FAIL vga_unexpected actual cyc=%0d data=%0h required=no fetch", cyc, bus.oVgaData);
        end else begin
          vga_exp = vga_exp_q.pop_front();
          if (vga_got !== vga_exp) begin
            failures++;
            $display("FAIL vga_fetch actual cyc=%0d data=%0h required cyc=%0d data=%0h",
                     vga_got[VW-1:DATA_W], vga_got[DATA_W-1:0], vga_exp[VW-1:DATA_W], vga_exp[DATA_W-1:0]);
          end
        end
      end
      if (bus.oRamWe) begin
        wr_got = {CYC_W'(cyc), bus.oRamAddr, bus.oRamData};
        checks++;
        if (wr_exp_q.size() == 0) begin
          failures++;
          $display("FAIL ram_write_unexpected actual cyc=%0d addr=%0h data=%0h required=no write",
                   cyc, bus.oRamAddr, bus.oRamData);
        end else begin
          wr_exp = wr_exp_q.pop_front();
          if (wr_got !== wr_exp) begin
            failures++;
            $display("FAIL ram_write actual cyc=%0d addr=%0h data=%0h required cyc=%0d addr=%0h data=%0h",
                     wr_got[WW-1:ADDR_W+DATA_W], wr_got[ADDR_W+DATA_W-1:DATA_W], wr_got[DATA_W-1:0],
                     wr_exp[WW-1:ADDR_W+DATA_W], wr_exp[ADDR_W+DATA_W-1:DATA_W], wr_exp[DATA_W-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One cycle of stimulus. wdelay: cycles until the store must appear on the
  // RAM port (-1 when the store is expected to be dropped).
  task automatic drive(input bit vreq, input logic [ADDR_W-1:0] vaddr, input logic [DATA_W-1:0] vexp,
                       input bit sreq, input logic [ADDR_W-1:0] saddr, input logic [DATA_W-1:0] sdata,
                       input int wdelay);
    bus.iVgaReq  = vreq;
    bus.iVgaAddr = vaddr;
    bus.iCpuWrEn = sreq;
    bus.iCpuAddr = saddr;
    bus.iCpuData = sdata;
    if (vreq) vga_exp_q.push_back({CYC_W'(cyc + 3), vexp});
    if (sreq && wdelay >= 0) wr_exp_q.push_back({CYC_W'(cyc + wdelay), saddr, sdata});
    tick();
    bus.iVgaReq  = 1'b0;
    bus.iCpuWrEn = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = '0;
    ram[15'h0010] = 3'b101;
    for (int a = 0; a < 16; a++) ram[15'h0020 + a] = a[2:0];

    Reset        = 1'b1;
    bus.iVgaReq  = 1'b0;
    bus.iVgaAddr = '0;
    bus.iCpuWrEn = 1'b0;
    bus.iCpuAddr = '0;
    bus.iCpuData = '0;
    repeat (2) tick();

    // Reset state
    check("rst_ramWe",    32'(bus.oRamWe),       0);
    check("rst_ramAddr",  32'(bus.oRamAddr),     0);
    check("rst_ramData",  32'(bus.oRamData),     0);
    check("rst_vgaValid", 32'(bus.oVgaValid),    0);
    check("rst_vgaData",  32'(bus.oVgaData),     0);
    check("rst_cpuReady", 32'(bus.oCpuReady),    1);
    check("rst_overflow", 32'(bus.oCpuOverflow), 0);
    check("rst_gnt",      32'(bus.dbgGntState),  32'(GNT_IDLE));
    check("rst_count",    32'(bus.dbgFifoCount), 0);
    Reset = 1'b0;
    repeat (2) tick();

    // Single fetch: 0x0010 holds 3'b101, data back exactly 3 cycles later
    drive(1, 15'h0010, 3'b101, 0, '0, '0, -1);
    repeat (5) tick();

    // Store drain: idle VGA, write appears 2 cycles after acceptance, once
    drive(0, '0, '0, 1, 15'h0123, 3'b011, 2);
    repeat (5) tick();

    // Priority/full: VGA held 10 cycles, 5 stores -> 4 buffered, 5th dropped;
    // writes drain on 4 consecutive cycles once VGA releases.
    for (int i = 0; i < 10; i++) begin
      if (i == 3) check("full_ready_before4", 32'(bus.oCpuReady), 1);
      if (i == 4) begin
        check("full_ready_after4", 32'(bus.oCpuReady),    0);
        check("full_count4",       32'(bus.dbgFifoCount), 4);
        check("full_ovf_before5",  32'(bus.oCpuOverflow), 0);
      end
      if (i == 5) check("full_ovf_after5", 32'(bus.oCpuOverflow), 1);
      if (i == 6) check("full_gnt_vga",    32'(bus.dbgGntState),  32'(GNT_VGA));
      drive(1, ADDR_W'(32'h20 + i), i[2:0], (i < 5), ADDR_W'(32'h100 + i), DATA_W'(i + 1),
            (i < 4) ? 11 : -1);
    end
    tick();
    check("full_ready_after_pop", 32'(bus.oCpuReady),   1);
    check("full_gnt_cpu",         32'(bus.dbgGntState), 32'(GNT_CPU));
    repeat (6) tick();

    // Interleave: VGA every other cycle, stores land in the gaps
    drive(1, 15'h0021, 3'd1, 1, 15'h0200, 3'b110, 2);
    drive(0, '0, '0, 1, 15'h0201, 3'b001, 3);
    drive(1, 15'h0022, 3'd2, 0, '0, '0, -1);
    drive(0, '0, '0, 0, '0, '0, -1);
    drive(1, 15'h0023, 3'd3, 0, '0, '0, -1);
    drive(0, '0, '0, 0, '0, '0, -1);
    drive(1, 15'h0024, 3'd4, 0, '0, '0, -1);
    repeat (5) tick();

    // Simultaneous push/pop at count = FIFO_DEPTH-1
    drive(1, 15'h0025, 3'd5, 1, 15'h0300, 3'b111, 4);
    drive(1, 15'h0026, 3'd6, 1, 15'h0301, 3'b010, 4);
    drive(1, 15'h0027, 3'd7, 1, 15'h0302, 3'b100, 4);
    check("pp_count_before", 32'(bus.dbgFifoCount), 3);
    drive(0, '0, '0, 1, 15'h0303, 3'b101, 4);
    check("pp_count_after", 32'(bus.dbgFifoCount), 3);
    check("pp_ready_after", 32'(bus.oCpuReady),    1);
    repeat (6) tick();

    // Reset mid-drain: 3 stores buffered under VGA, none must ever be written.
    // Only the first fetch completes before reset.
    drive(1, 15'h0028, 3'd0, 1, 15'h0400, 3'b001, -1);
    bus.iVgaReq  = 1'b1;
    bus.iVgaAddr = 15'h0029;
    bus.iCpuWrEn = 1'b1;
    bus.iCpuAddr = 15'h0401;
    tick();
    bus.iCpuAddr = 15'h0402;
    tick();
    bus.iCpuWrEn = 1'b0;
    tick();
    check("rstd_count_before", 32'(bus.dbgFifoCount), 3);
    check("rstd_ovf_before",   32'(bus.oCpuOverflow), 1);
    Reset = 1'b1;
    #1;
    check("rstd_ramWe",    32'(bus.oRamWe),       0);
    check("rstd_cpuReady", 32'(bus.oCpuReady),    1);
    check("rstd_count",    32'(bus.dbgFifoCount), 0);
    check("rstd_overflow", 32'(bus.oCpuOverflow), 0);
    check("rstd_vgaValid", 32'(bus.oVgaValid),    0);
    bus.iVgaReq = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;
    repeat (8) tick();
    check("rstd_gnt_idle", 32'(bus.dbgGntState), 32'(GNT_IDLE));

    // Every expected fetch and write must have been observed
    check("vga_queue_drained", 32'(vga_exp_q.size()), 0);
    check("wr_queue_drained",  32'(wr_exp_q.size()),  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
